video_pattern_checker: RTL

VIDEO_PATTERN_CHECKER -- requirements
Module: video_pattern_checker

---
 rtl/video_pkg.sv | 15 +
 rtl/video_pattern_ref.sv | 31 +++
 rtl/video_pattern_checker.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/video_pkg.sv
// Shared types and constants for the video colour-bar pattern checker.
package video_pkg;

    typedef logic [23:0] pixel_t;

    localparam pixel_t COLOR_Q1 = 24'h00CC00;
    localparam pixel_t COLOR_Q2 = 24'h00CCCC;
    localparam pixel_t COLOR_Q3 = 24'hFF9A26;
    localparam pixel_t COLOR_Q4 = 24'h9D26FF;

    localparam int DEFAULT_WIDTH      = 800;
    localparam int DEFAULT_HEIGHT     = 600;
    localparam int DEFAULT_FRAME_RATE = 72;

endpackage

// File: rtl/video_pattern_ref.sv
// Expected pixel colour for a raster position: quadrant select from x[6]/y[5],
// inverted while phase is 0.
module video_pattern_ref
    import video_pkg::*;
(
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       phase,
    output pixel_t     color
);

    pixel_t base;

    always_comb begin
        base = COLOR_Q1;
        case ({y[5], x[6]})
            2'b00: base = COLOR_Q1;
            2'b01: base = COLOR_Q2;
            2'b10: base = COLOR_Q3;
            2'b11: base = COLOR_Q4;
            default: base = COLOR_Q1;
        endcase
    end

    assign color = phase ? base : ~base;

    // Only the quadrant bits select the colour.
    logic unused_bits;
    assign unused_bits = ^{x[9:7], x[5:0], y[9:6], y[4:0]};

endmodule

// File: rtl/video_pattern_checker.sv
// Checks an incoming RGB stream against the quadrant test pattern and keeps error stats.
// Optional macro VIDEO_CHECK_BACKPRESSURE_EN: VideoReady driven by a 16-bit LFSR.
module video_pattern_checker
    import video_pkg::*;
#(
    parameter int VISIBLE_WIDTH  = DEFAULT_WIDTH,
    parameter int VISIBLE_HEIGHT = DEFAULT_HEIGHT,
    parameter int FRAME_RATE     = DEFAULT_FRAME_RATE,
    parameter int ERR_W          = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [23:0]      Video,
    input  logic             VideoValid,
    output logic             VideoReady,
    input  logic             clear,
    output logic             frame_done,
    output logic             frame_err,
    output logic [6:0]       frame_count,
    output logic [ERR_W-1:0] error_count,
    output logic [9:0]       first_err_x,
    output logic [9:0]       first_err_y,
    output logic             first_err_valid
);

    localparam logic [9:0] X_LAST  = 10'(VISIBLE_WIDTH - 1);
    localparam logic [9:0] Y_LAST  = 10'(VISIBLE_HEIGHT - 1);
    localparam logic [6:0] FC_LAST = 7'(FRAME_RATE - 1);

    logic [9:0] x, y;
    logic       phase;
    pixel_t     expected;
    logic       accept, last_px, ready_r;

    // Compare stage: one accepted pixel in flight.
    logic       s1_valid, s1_mis, s1_last;
    logic [9:0] s1_x, s1_y;
    logic       frame_flag;

`ifdef VIDEO_CHECK_BACKPRESSURE_EN
    logic [15:0] lfsr;
    always_ff @(posedge clock) begin
        if (reset) lfsr <= 16'hACE1;
        else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
    assign ready_r = lfsr[0];
`else
    always_ff @(posedge clock) begin
        if (reset) ready_r <= 1'b0;
        else       ready_r <= 1'b1;
    end
`endif

    assign VideoReady = ready_r & ~reset;
    assign accept     = VideoValid & VideoReady;
    assign last_px    = (x == X_LAST) && (y == Y_LAST);

    video_pattern_ref u_ref (
        .x     (x),
        .y     (y),
        .phase (phase),
        .color (expected)
    );

    // Raster position and frame/phase bookkeeping advance on the accepting edge,
    // so a pixel accepted right after a frame end already sees the new phase.
    always_ff @(posedge clock) begin
        if (reset) begin
            x           <= '0;
            y           <= '0;
            phase       <= 1'b0;
            frame_count <= '0;
        end else if (accept) begin
            if (x == X_LAST) begin
                x <= '0;
                if (y == Y_LAST) begin
                    y <= '0;
                    if (frame_count == FC_LAST) begin
                        frame_count <= '0;
                        phase       <= ~phase;
                    end else begin
                        frame_count <= frame_count + 7'd1;
                    end
                end else begin
                    y <= y + 10'd1;
                end
            end else begin
                x <= x + 10'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_mis   <= 1'b0;
            s1_last  <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_mis  <= (Video != expected);
                s1_last <= last_px;
                s1_x    <= x;
                s1_y    <= y;
            end
        end
    end

    // Statistics; clear beats a mismatch landing in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            frame_done      <= 1'b0;
            frame_err       <= 1'b0;
            frame_flag      <= 1'b0;
            error_count     <= '0;
            first_err_x     <= '0;
            first_err_y     <= '0;
            first_err_valid <= 1'b0;
        end else begin
            frame_done <= s1_valid & s1_last;
            if (s1_valid) begin
                if (s1_last) begin
                    frame_err  <= frame_flag | s1_mis;
                    frame_flag <= 1'b0;
                end else if (s1_mis) begin
                    frame_flag <= 1'b1;
                end
            end
            if (clear) begin
                error_count     <= '0;
                first_err_valid <= 1'b0;
            end else if (s1_valid && s1_mis) begin
                if (error_count != '1) error_count <= error_count + ERR_W'(1);
                if (!first_err_valid) begin
                    first_err_x     <= s1_x;
                    first_err_y     <= s1_y;
                    first_err_valid <= 1'b1;
                end
            end
        end
    end

endmodule
